// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Accepts one instruction (opcode, dst, operand) at a time. Each
//             instruction is written as three consecutive bytes into program
//             memory at the write pointer: opcode, {4'b0,dst}, operand.
//             Illegal opcodes set a sticky error flag and are dropped.
//  Ports    : clk, rst_n (async, active-low)
//             load_addr/base_addr   - reload write pointer (IDLE only)
//             in_valid/in_ready     - instruction handshake
//             in_opcode/in_dst/in_operand - instruction fields
//             mem_we/mem_addr/mem_wdata   - byte write port
//             mem_busy              - stalls the current write
//             full, err, count      - status
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int MAX_OPCODE = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_opcode,
  input  logic [3:0]        in_dst,
  input  logic [7:0]        in_operand,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_W_OP   = 2'd1;
  localparam logic [1:0] S_W_DST  = 2'd2;
  localparam logic [1:0] S_W_OPND = 2'd3;

  // Pointer values above this leave fewer than three bytes of room.
  localparam logic [ADDR_W-1:0] C_PTR_LIMIT = {ADDR_W{1'b1}} - ADDR_W'(2);
  localparam logic [ADDR_W-1:0] C_CNT_MAX   = {ADDR_W{1'b1}};
  localparam logic [7:0]        C_OPC_MAX   = 8'(MAX_OPCODE);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_count;
  logic              r_err;
  logic [7:0]        r_opcode;
  logic [3:0]        r_dst;
  logic [7:0]        r_operand;

  logic w_offer;
  logic w_legal;
  logic w_accept;
  logic w_taken;

  assign full     = (r_ptr > C_PTR_LIMIT);
  assign in_ready = (r_state == S_IDLE) && !full && !load_addr;
  assign w_offer  = in_valid && in_ready;
  assign w_legal  = (in_opcode <= C_OPC_MAX);
  assign w_accept = w_offer && w_legal;
  assign w_taken  = mem_we && !mem_busy;

  assign mem_addr = r_ptr;
  assign err      = r_err;
  assign count    = r_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: every write state advances only on a taken write
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next_state = S_W_OP;
      S_W_OP:   if (w_taken)  w_next_state = S_W_DST;
      S_W_DST:  if (w_taken)  w_next_state = S_W_OPND;
      S_W_OPND: if (w_taken)  w_next_state = S_IDLE;
      default:                w_next_state = S_IDLE;
    endcase
  end

  // Output logic: strobe and byte selection from state alone, so an
  // asynchronous reset kills the strobe immediately.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (r_state)
      S_W_OP: begin
        mem_we    = 1'b1;
        mem_wdata = r_opcode;
      end
      S_W_DST: begin
        mem_we    = 1'b1;
        mem_wdata = {4'b0000, r_dst};
      end
      S_W_OPND: begin
        mem_we    = 1'b1;
        mem_wdata = r_operand;
      end
      default: begin
        mem_we    = 1'b0;
        mem_wdata = 8'h00;
      end
    endcase
  end

  // Datapath: pointer, instruction count, sticky error, latched fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_opcode  <= 8'h00;
      r_dst     <= 4'h0;
      r_operand <= 8'h00;
    end else if (r_state == S_IDLE) begin
      // load_addr forces in_ready low, so it never coincides with an offer
      if (load_addr) begin
        r_ptr   <= base_addr;
        r_count <= '0;
      end
      if (w_offer && !w_legal) begin
        r_err <= 1'b1;
      end
      if (w_accept) begin
        r_opcode  <= in_opcode;
        r_dst     <= in_dst;
        r_operand <= in_operand;
      end
    end else if (w_taken) begin
      r_ptr <= r_ptr + ADDR_W'(1);
      if ((r_state == S_W_OPND) && (r_count != C_CNT_MAX)) begin
        r_count <= r_count + ADDR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder. A byte-level reference
//             model (pointer, count, sticky error) predicts every write.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

  localparam int ADDR_W     = 8;
  localparam int MAX_OPCODE = 26;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_addr = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0]        in_opcode = 8'h00;
  logic [3:0]        in_dst = 4'h0;
  logic [7:0]        in_operand = 8'h00;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_busy = 1'b0;
  logic              full;
  logic              err;
  logic [ADDR_W-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int m_ptr   = 0;
  int m_count = 0;
  bit m_err   = 1'b0;

  instr_encoder #(.ADDR_W(ADDR_W), .MAX_OPCODE(MAX_OPCODE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_addr  (load_addr),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_dst     (in_dst),
    .in_operand (in_operand),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_busy   (mem_busy),
    .full       (full),
    .err        (err),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic bit m_full();
    return m_ptr > ((1 << ADDR_W) - 3);
  endfunction

  // Offer one legal instruction and follow its three writes.
  // busy_mode: 0 no stalls, 1 random stalls, 2 two-cycle stall on the dst byte
  task automatic run_instr(input logic [7:0] op, input logic [3:0] dst,
                           input logic [7:0] opnd, input int busy_mode,
                           input bit load_mid);
    logic [7:0] ea [3];
    logic [7:0] ed [3];
    int k, cyc, bcnt, hold;
    bit busy;
    for (int i = 0; i < 3; i++) ea[i] = 8'((m_ptr + i) % 256);
    ed[0] = op;
    ed[1] = {4'b0000, dst};
    ed[2] = opnd;

    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_dst = dst; in_operand = opnd;
    mem_busy = 1'b0; load_addr = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0; cyc = 0; bcnt = 0; hold = 0;
    while (k < 3 && cyc < 64) begin
      case (busy_mode)
        1:       busy = ($urandom_range(0, 99) < 30);
        2:       busy = (k == 1) && (hold < 2);
        default: busy = 1'b0;
      endcase
      mem_busy  = busy;
      load_addr = load_mid && (cyc == 0);
      base_addr = 8'h80;
      #1;
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== ea[k] || mem_wdata !== ed[k]) begin
        miscompares++;
        $display("FAIL write_byte%0d: we=%b addr=%h data=%h required we=1 addr=%h data=%h",
                 k, mem_we, mem_addr, mem_wdata, ea[k], ed[k]);
      end
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL busy_ready: in_ready=%b required 0 while writing", in_ready);
      end
      if (k == 1 && busy) hold++;
      bcnt++;
      if (!busy) begin
        if (busy_mode == 2 && k == 1) begin
          vectors++;
          if (bcnt != 3) begin
            miscompares++;
            $display("FAIL dst_hold: dst byte presented %0d cycles required 3", bcnt);
          end
        end
        k++;
        bcnt = 0;
      end
      cyc++;
      @(negedge clk);
    end
    mem_busy  = 1'b0;
    load_addr = 1'b0;
    if (k < 3) begin
      vectors++;
      miscompares++;
      $display("FAIL write_timeout: %0d of 3 bytes written required 3", k);
    end
    if (busy_mode == 0) begin
      vectors++;
      if (cyc != 3) begin
        miscompares++;
        $display("FAIL latency: %0d write cycles required 3", cyc);
      end
    end
    m_ptr   = (m_ptr + 3) % 256;
    m_count = (m_count < 255) ? m_count + 1 : 255;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || in_ready !== !m_full() || count !== 8'(m_count)
        || full !== m_full() || mem_addr !== 8'(m_ptr) || mem_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL post_instr: we=%b rdy=%b cnt=%0d full=%b addr=%h wd=%h required we=0 rdy=%b cnt=%0d full=%b addr=%h wd=00",
               mem_we, in_ready, count, full, mem_addr, mem_wdata,
               !m_full(), m_count, m_full(), 8'(m_ptr));
    end
  endtask

  task automatic do_load(input logic [7:0] base);
    @(negedge clk);
    in_valid = 1'b0; load_addr = 1'b1; base_addr = base;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_ready: in_ready=%b required 0 during load", in_ready);
    end
    @(negedge clk);
    load_addr = 1'b0;
    m_ptr = base; m_count = 0;
    #1;
    vectors++;
    if (mem_addr !== base || count !== 8'h00 || full !== m_full()) begin
      miscompares++;
      $display("FAIL load: addr=%h cnt=%0d full=%b required addr=%h cnt=0 full=%b",
               mem_addr, count, full, base, m_full());
    end
  endtask

  task automatic offer_illegal(input logic [7:0] op);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = op; in_dst = 4'hF; in_operand = 8'hFF;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_ready: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    m_err = 1'b1;
    #1;
    vectors++;
    if (err !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b1 || mem_addr !== 8'(m_ptr)) begin
      miscompares++;
      $display("FAIL illegal: err=%b we=%b rdy=%b addr=%h required err=1 we=0 rdy=1 addr=%h",
               err, mem_we, in_ready, mem_addr, 8'(m_ptr));
    end
    @(negedge clk);
    #1;
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_nowrite: we=%b required 0", mem_we);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (mem_we !== 1'b0 || mem_wdata !== 8'h00 || mem_addr !== 8'h00
        || count !== 8'h00 || err !== 1'b0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: we=%b wd=%h addr=%h cnt=%0d err=%b full=%b required all 0",
               mem_we, mem_wdata, mem_addr, count, err, full);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: rdy=%b we=%b required rdy=1 we=0", in_ready, mem_we);
    end
    m_ptr = 0; m_count = 0; m_err = 1'b0;
  endtask

  task automatic test_basic();
    do_load(8'h10);
    run_instr(8'h03, 4'h2, 8'h5A, 0, 1'b0);
  endtask

  task automatic test_busy();
    do_load(8'h10);
    run_instr(8'h03, 4'h2, 8'h5A, 2, 1'b0);
  endtask

  task automatic test_illegal();
    offer_illegal(8'h1B);
    run_instr(8'h1A, 4'h7, 8'hC3, 0, 1'b0);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: err=%b required 1", err);
    end
  endtask

  task automatic test_full();
    do_load(8'hFC);
    run_instr(8'h11, 4'h9, 8'h42, 0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 8'h05; in_dst = 4'h1; in_operand = 8'h01;
    #1;
    vectors++;
    if (full !== 1'b1 || in_ready !== 1'b0 || mem_addr !== 8'hFF) begin
      miscompares++;
      $display("FAIL full: full=%b rdy=%b addr=%h required full=1 rdy=0 addr=ff",
               full, in_ready, mem_addr);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL full_nowrite: we=%b required 0", mem_we);
    end
    do_load(8'h00);
    vectors++;
    if (full !== 1'b0 || count !== 8'h00 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL full_clear: full=%b cnt=%0d rdy=%b required 0 0 1", full, count, in_ready);
    end
  endtask

  task automatic test_load_ignored();
    do_load(8'h20);
    run_instr(8'h08, 4'hA, 8'h99, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    do_load(8'h40);
    @(negedge clk);
    in_valid = 1'b1; in_opcode = 8'h02; in_dst = 4'h3; in_operand = 8'h77;
    @(negedge clk);
    in_valid = 1'b0; mem_busy = 1'b0;
    @(negedge clk);
    mem_busy = 1'b1;
    #1;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h41 || mem_wdata !== 8'h03) begin
      miscompares++;
      $display("FAIL mid_wdst: we=%b addr=%h data=%h required we=1 addr=41 data=03",
               mem_we, mem_addr, mem_wdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: we=%b wd=%h required 0 00", mem_we, mem_wdata);
    end
    @(negedge clk);
    mem_busy = 1'b0;
    rst_n = 1'b1;
    m_ptr = 0; m_count = 0; m_err = 1'b0;
    #1;
    vectors++;
    if (mem_addr !== 8'h00 || count !== 8'h00 || err !== 1'b0
        || mem_we !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset_release: addr=%h cnt=%0d err=%b we=%b rdy=%b required 00 0 0 0 1",
               mem_addr, count, err, mem_we, in_ready);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_nostrobe: we=%b required 0", mem_we);
    end
  endtask

  task automatic test_random();
    int r;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (m_full() || r == 0) begin
        do_load(8'($urandom_range(0, 255)));
      end else if (r == 1) begin
        offer_illegal(8'($urandom_range(MAX_OPCODE + 1, 255)));
      end else begin
        run_instr(8'($urandom_range(0, MAX_OPCODE)), 4'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 1, 1'b0);
      end
      vectors++;
      if (err !== m_err || count !== 8'(m_count)) begin
        miscompares++;
        $display("FAIL random_status: err=%b cnt=%0d required err=%b cnt=%0d",
                 err, count, m_err, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_illegal();
    test_full();
    test_load_ignored();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
